// File: rtl/phy_free_list_pkg.sv
// Shared sizing and types for the physical register free list.
package phy_free_list_pkg;

  localparam int unsigned PRF_DEPTH = 64;
  localparam int unsigned ARF_DEPTH = 32;
  localparam int unsigned FL_DEPTH  = PRF_DEPTH - ARF_DEPTH;
  localparam int unsigned PRF_IDX   = $clog2(PRF_DEPTH);
  localparam int unsigned FL_IDX    = $clog2(FL_DEPTH);
  localparam int unsigned FL_PTR_W  = FL_IDX + 1;

  typedef logic [PRF_IDX-1:0] phy_idx_t;

  typedef struct packed {
    logic              wrap;
    logic [FL_IDX-1:0] idx;
  } fl_ptr_t;

endpackage

// File: rtl/phy_free_list.sv
// Circular free list of physical register indices with a committed head for one-cycle flush.
// Optional FREE_LIST_BYPASS_EN: a freed index is allocatable in the same cycle when the list is empty.
module phy_free_list
  import phy_free_list_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  output logic                alloc_valid,
  output phy_idx_t            alloc_phy,
  input  logic                alloc_ready,
  input  logic                commit_en,
  input  logic                free_en,
  input  phy_idx_t            free_phy,
  input  logic                flush,
  output logic [FL_PTR_W-1:0] free_count
);

  function automatic fl_ptr_t ptr_inc(fl_ptr_t p);
    logic [FL_PTR_W-1:0] v;
    v = p + FL_PTR_W'(1);
    return v;
  endfunction

  function automatic logic ptr_full(fl_ptr_t t, fl_ptr_t h);
    return (t.idx == h.idx) && (t.wrap != h.wrap);
  endfunction

  phy_idx_t mem_q [FL_DEPTH];
  fl_ptr_t  head_q, head_d, cmt_head_q, cmt_head_d, tail_q, tail_d;
  logic     empty, full, free_ok, push, pop, bypass;

  assign empty   = (head_q == tail_q);
  assign full    = ptr_full(tail_q, head_q);
  assign free_ok = free_en && (free_phy != '0);
  assign push    = free_ok && !full;

`ifdef FREE_LIST_BYPASS_EN
  assign bypass = empty && free_ok && !flush;
`else
  assign bypass = 1'b0;
`endif

  assign alloc_valid = (!empty && !flush) || bypass;
  assign alloc_phy   = bypass ? free_phy : mem_q[head_q.idx];
  assign pop         = alloc_valid && alloc_ready;
  assign free_count  = tail_q - head_q;

  always_comb begin
    tail_d     = push ? ptr_inc(tail_q) : tail_q;
    cmt_head_d = commit_en ? ptr_inc(cmt_head_q) : cmt_head_q;
    head_d     = head_q;
    if (flush) begin
      // Recovery sees this cycle's commit too.
      head_d = cmt_head_d;
    end else if (pop) begin
      head_d = ptr_inc(head_q);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FL_DEPTH; i++) begin
        mem_q[i] <= phy_idx_t'(ARF_DEPTH + i);
      end
      head_q     <= '0;
      cmt_head_q <= '0;
      tail_q     <= '{wrap: 1'b1, idx: '0};
    end else begin
      if (push) begin
        mem_q[tail_q.idx] <= free_phy;
      end
      head_q     <= head_d;
      cmt_head_q <= cmt_head_d;
      tail_q     <= tail_d;
    end
  end

`ifndef SYNTHESIS
  logic [FL_PTR_W-1:0] live;
  assign live = tail_q - cmt_head_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      assert (!(free_en && full)) else $error("free_en while free list full");
      assert (!(commit_en && !pop && (cmt_head_q == head_q)))
        else $error("commit head passed speculative head");
      if (push) begin
        // Everything from the committed head to the tail is still owned by the list.
        for (int i = 0; i < FL_DEPTH; i++) begin
          if (FL_PTR_W'(i) < live) begin
            assert (mem_q[FL_IDX'(cmt_head_q.idx + FL_IDX'(i))] != free_phy)
              else $error("duplicate push of p%0d", free_phy);
          end
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_phy_free_list.sv
// Self-checking bench for phy_free_list: directed scenarios plus a random phase against a queue model.
module tb_phy_free_list;
  import phy_free_list_pkg::*;

`ifdef FREE_LIST_BYPASS_EN
  localparam bit Bypass = 1'b1;
`else
  localparam bit Bypass = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst;
  logic                alloc_valid, alloc_ready, commit_en, free_en, flush;
  phy_idx_t            alloc_phy, free_phy;
  logic [FL_PTR_W-1:0] free_count;

  int checks = 0;
  int errors = 0;

  // Model: q holds every entry from the committed head onward; the first spec of them are
  // speculatively allocated. pool holds mapped indices that may legally be freed later.
  int q[$];
  int pool[$];
  int spec;

  logic        obs_valid;
  logic [31:0] obs_phy, obs_count;

  always #5 clk = ~clk;

  phy_free_list dut (
    .clk        (clk),
    .rst        (rst),
    .alloc_valid(alloc_valid),
    .alloc_phy  (alloc_phy),
    .alloc_ready(alloc_ready),
    .commit_en  (commit_en),
    .free_en    (free_en),
    .free_phy   (free_phy),
    .flush      (flush),
    .free_count (free_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    pool.delete();
    for (int i = 0; i < FL_DEPTH; i++) q.push_back(ARF_DEPTH + i);
    for (int i = 1; i < ARF_DEPTH; i++) pool.push_back(i);
    spec = 0;
  endtask

  function automatic int take_rand();
    int k, v;
    k = $urandom_range(pool.size() - 1);
    v = pool[k];
    pool.delete(k);
    return v;
  endfunction

  function automatic int take(input int val);
    for (int i = 0; i < pool.size(); i++) begin
      if (pool[i] == val) begin
        pool.delete(i);
        break;
      end
    end
    return val;
  endfunction

  task automatic idle_inputs();
    alloc_ready = 1'b0;
    free_en     = 1'b0;
    free_phy    = '0;
    commit_en   = 1'b0;
    flush       = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1'b0;
    #3;
    rst = 1'b1;
    model_reset();
  endtask

  // One clock: drive, check combinational outputs against the model, then advance the model.
  task automatic step(input bit rdy, input bit fen, input int fphy, input bit cen, input bit fl);
    int avail;
    bit ev;
    @(negedge clk);
    alloc_ready = rdy;
    free_en     = fen;
    free_phy    = phy_idx_t'(fphy);
    commit_en   = cen;
    flush       = fl;
    #1;
    avail = q.size() - spec;
    ev = !fl && ((avail > 0) || (Bypass && fen && (fphy != 0)));
    obs_valid = alloc_valid;
    obs_phy   = 32'(alloc_phy);
    obs_count = 32'(free_count);
    check("alloc_valid", alloc_valid, ev);
    if (ev) check("alloc_phy", alloc_phy, (avail > 0) ? q[spec] : fphy);
    check("free_count", free_count, avail);
    @(posedge clk);
    if (fen && (fphy != 0)) q.push_back(fphy);
    if (ev && rdy) spec++;
    if (cen) begin
      pool.push_back(q.pop_front());
      spec--;
    end
    if (fl) spec = 0;
  endtask

  initial begin
    bit rdy, fen, cen, fl;
    int fphy;

    idle_inputs();
    rst = 1'b0;
    model_reset();
    #12;
    check("reset_valid", alloc_valid, 1);
    check("reset_phy", alloc_phy, ARF_DEPTH);
    check("reset_count", free_count, FL_DEPTH);
    @(negedge clk);
    rst = 1'b1;

    // Drain the whole list in order.
    for (int i = 0; i < FL_DEPTH; i++) begin
      step(1, 0, 0, 0, 0);
      check("t1_phy", obs_phy, ARF_DEPTH + i);
    end
    step(0, 0, 0, 0, 0);
    check("t1_empty_valid", obs_valid, 0);
    check("t1_empty_count", obs_count, 0);

    // Free into an empty list.
    step(0, 1, take(7), 0, 0);
    check("t4_same_valid", obs_valid, Bypass);
    step(0, 0, 0, 0, 0);
    check("t4_next_valid", obs_valid, 1);
    check("t4_next_phy", obs_phy, 7);

    // p0 is never pushed.
    step(0, 1, 0, 0, 0);
    check("t5_count_before", obs_count, 1);
    step(0, 0, 0, 0, 0);
    check("t5_count_after", obs_count, 1);

    // Pop the 7, then free+alloc on an empty list.
    step(1, 0, 0, 0, 0);
    step(1, 1, take(9), 0, 0);
    step(0, 0, 0, 0, 0);
    check("t4b_count", obs_count, Bypass ? 0 : 1);

    // Push and pop together keep the count steady; tail wraps.
    do_reset();
    step(1, 0, 0, 0, 0);
    check("t2_first_phy", obs_phy, ARF_DEPTH);
    step(1, 1, take(5), 0, 0);
    check("t2_count_during", obs_count, FL_DEPTH - 1);
    step(0, 0, 0, 0, 0);
    check("t2_count_after", obs_count, FL_DEPTH - 1);

    // Flush returns uncommitted allocations.
    do_reset();
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 1);
    check("t3_flush_valid", obs_valid, 0);
    step(0, 0, 0, 0, 0);
    check("t3_phy", obs_phy, ARF_DEPTH + 2);
    check("t3_count", obs_count, FL_DEPTH - 2);

    // Random legal traffic.
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      rdy  = ($urandom % 4) != 0;
      fen  = 1'b0;
      fphy = 0;
      if ((pool.size() > 0) && (q.size() < FL_DEPTH) && (($urandom % 3) == 0)) begin
        fen  = 1'b1;
        fphy = (($urandom % 10) == 0) ? 0 : take_rand();
      end
      cen = (spec > 0) && (($urandom % 3) == 0);
      fl  = ($urandom % 40) == 0;
      step(rdy, fen, fphy, cen, fl);
    end

    // Asynchronous reset between edges mid-burst.
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0);
    #1;
    idle_inputs();
    #1;
    rst = 1'b0;
    #1;
    check("t6_valid", alloc_valid, 1);
    check("t6_phy", alloc_phy, ARF_DEPTH);
    check("t6_count", free_count, FL_DEPTH);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    check("t6_after_count", obs_count, FL_DEPTH - 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
